// File: rtl/mem_req_arbiter_if.sv
// Bundle of every handshake and bus signal around mem_req_arbiter.
//  Fetch side : i_req, i_addr -> ; <- i_busy, i_done, i_data
//  Data side  : d_req, d_wr, d_addr, d_wdata -> ; <- d_busy, d_done, d_data
//  Memory side: <- mem_addr, mem_wdata, mem_rd, mem_wr ; mem_done, mem_rdata, mem_err ->
//  Status     : <- err (sticky)
// Modport slave is the arbiter's view; modport master is the view of whatever
// surrounds it (pipeline requesters plus mem_system).
interface mem_req_arbiter_if;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_busy;
    logic        i_done;
    logic [15:0] i_data;

    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_busy;
    logic        d_done;
    logic [15:0] d_data;

    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        mem_err;

    logic        err;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
               mem_done, mem_rdata, mem_err,
        output i_busy, i_done, i_data, d_busy, d_done, d_data,
               mem_addr, mem_wdata, mem_rd, mem_wr, err
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
               mem_done, mem_rdata, mem_err,
        input  i_busy, i_done, i_data, d_busy, d_done, d_data,
               mem_addr, mem_wdata, mem_rd, mem_wr, err
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: front end of mem_system. Latches single-cycle fetch (I)
// and data (D) requests, grants one at a time (D preferred, with a starvation
// limit protecting I), issues a one-cycle Rd/Wr to mem_system, holds
// Addr/DataIn until Done, then pulses the owner's done with the result.
//  clk, rst  : clock, synchronous active-high reset
//  bus       : mem_req_arbiter_if.slave (requester, memory and err signals)
// Parameters: STARVE_MAX (1..15) consecutive D grants while I waits,
//             TIMEOUT (1..255) WAIT cycles without Done before giving up.
module mem_req_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    mem_req_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    state_t      state, stateNext;

    // Pending slots double as busy: a slot stays set from capture until its
    // completion, so it covers both "waiting" and "in flight".
    logic        iPend, dPend;
    logic [15:0] iAddr, dAddr, dWdata;
    logic        dWr;

    logic        ownerD;
    logic        opWr;
    logic [3:0]  starveCnt;
    logic [7:0]  waitCnt;

    logic        grantD, grantI, complete, timedOut;

    logic [15:0] memAddr, memWdata, iData, dData;
    logic        memRd, memWr, iDone, dDone, errReg;

    assign bus.i_busy    = iPend;
    assign bus.d_busy    = dPend;
    assign bus.i_done    = iDone;
    assign bus.d_done    = dDone;
    assign bus.i_data    = iData;
    assign bus.d_data    = dData;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.mem_rd    = memRd;
    assign bus.mem_wr    = memWr;
    assign bus.err       = errReg;

    always_comb begin
        stateNext = state;
        grantD    = 1'b0;
        grantI    = 1'b0;
        complete  = 1'b0;
        timedOut  = 1'b0;
        case (state)
            IDLE: begin
                if (dPend && (!iPend || starveCnt < STARVE_LIM)) begin
                    grantD    = 1'b1;
                    stateNext = ISSUE;
                end else if (iPend) begin
                    grantI    = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_done) begin
                    complete  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                // waitCnt holds the number of earlier WAIT cycles, so this is
                // the TIMEOUT-th WAIT cycle when it equals TIMEOUT-1.
                if (bus.mem_done) begin
                    complete  = 1'b1;
                    stateNext = IDLE;
                end else if (waitCnt == WAIT_LAST) begin
                    complete  = 1'b1;
                    timedOut  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            iPend     <= 1'b0;
            dPend     <= 1'b0;
            iAddr     <= '0;
            dAddr     <= '0;
            dWdata    <= '0;
            dWr       <= 1'b0;
            ownerD    <= 1'b0;
            opWr      <= 1'b0;
            starveCnt <= '0;
            waitCnt   <= '0;
            memAddr   <= '0;
            memWdata  <= '0;
            memRd     <= 1'b0;
            memWr     <= 1'b0;
            iDone     <= 1'b0;
            dDone     <= 1'b0;
            iData     <= '0;
            dData     <= '0;
            errReg    <= 1'b0;
        end else begin
            state <= stateNext;
            memRd <= 1'b0;
            memWr <= 1'b0;
            iDone <= 1'b0;
            dDone <= 1'b0;

            if (bus.i_req && !iPend) begin
                iPend <= 1'b1;
                iAddr <= bus.i_addr;
            end
            if (bus.d_req && !dPend) begin
                dPend  <= 1'b1;
                dAddr  <= bus.d_addr;
                dWdata <= bus.d_wdata;
                dWr    <= bus.d_wr;
            end

            if (bus.mem_err || timedOut || (state == IDLE && bus.mem_done) ||
                (bus.i_req && iPend) || (bus.d_req && dPend)) begin
                errReg <= 1'b1;
            end

            if (grantD || grantI) begin
                ownerD   <= grantD;
                opWr     <= grantD && dWr;
                memAddr  <= grantD ? dAddr : iAddr;
                memWdata <= grantD ? dWdata : 16'h0000;
                memRd    <= !(grantD && dWr);
                memWr    <= grantD && dWr;
            end

            if (!iPend || grantI) begin
                starveCnt <= '0;
            end else if (grantD && starveCnt < STARVE_LIM) begin
                starveCnt <= starveCnt + 4'd1;
            end

            if (state == ISSUE) begin
                waitCnt <= '0;
            end else if (state == WAIT) begin
                waitCnt <= waitCnt + 8'd1;
            end

            // Clearing after capture: a request arriving on the owner's side
            // here is a busy violation and was already rejected above.
            if (complete) begin
                if (ownerD) begin
                    dDone <= 1'b1;
                    dData <= (opWr || timedOut) ? 16'h0000 : bus.mem_rdata;
                    dPend <= 1'b0;
                end else begin
                    iDone <= 1'b1;
                    iData <= timedOut ? 16'h0000 : bus.mem_rdata;
                    iPend <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_req_arbiter_if ifc ();

    mem_req_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;

    // Reference model: request slots, one in-flight transaction with an age
    // (0 = the issue cycle), and the visible result registers.
    logic        mIPend, mDPend, mDWr;
    logic [15:0] mIAddr, mDAddr, mDWdata;
    logic        txValid, txOwnerD, txWr;
    int          txAge;
    logic [15:0] mMemAddr, mMemWdata;
    logic        mIDone, mDDone, mErr;
    logic [15:0] mIData, mDData;
    int          mStarve;
    int          doneAge;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic modelStep();
        logic oldI, oldD, pickD, pickI;
        logic [15:0] res;
        if (rst) begin
            mIPend = 0; mDPend = 0; mDWr = 0; mIAddr = 0; mDAddr = 0; mDWdata = 0;
            txValid = 0; txOwnerD = 0; txWr = 0; txAge = 0;
            mMemAddr = 0; mMemWdata = 0; mIDone = 0; mDDone = 0; mErr = 0;
            mIData = 0; mDData = 0; mStarve = 0;
            return;
        end
        oldI = mIPend; oldD = mDPend;
        pickD = 0; pickI = 0;
        mIDone = 0; mDDone = 0;
        if (ifc.mem_err) mErr = 1;
        if (txValid) begin
            if (ifc.mem_done || txAge == TIMEOUT) begin
                res = (ifc.mem_done && !txWr) ? ifc.mem_rdata : 16'h0000;
                if (!ifc.mem_done) mErr = 1;
                if (txOwnerD) begin mDDone = 1; mDData = res; mDPend = 0; end
                else          begin mIDone = 1; mIData = res; mIPend = 0; end
                txValid = 0;
            end else begin
                txAge++;
            end
        end else begin
            if (ifc.mem_done) mErr = 1;
            pickD = oldD && (!oldI || mStarve < STARVE_MAX);
            pickI = !pickD && oldI;
            if (pickD || pickI) begin
                txValid = 1; txAge = 0; txOwnerD = pickD; txWr = pickD && mDWr;
                mMemAddr  = pickD ? mDAddr : mIAddr;
                mMemWdata = pickD ? mDWdata : 16'h0000;
            end
        end
        if (!oldI || pickI) mStarve = 0;
        else if (pickD && mStarve < STARVE_MAX) mStarve++;
        if (ifc.i_req) begin
            if (oldI) mErr = 1;
            else begin mIPend = 1; mIAddr = ifc.i_addr; end
        end
        if (ifc.d_req) begin
            if (oldD) mErr = 1;
            else begin mDPend = 1; mDAddr = ifc.d_addr; mDWdata = ifc.d_wdata; mDWr = ifc.d_wr; end
        end
    endtask

    task automatic compareAll();
        check("i_busy",    ifc.i_busy,    mIPend);
        check("d_busy",    ifc.d_busy,    mDPend);
        check("i_done",    ifc.i_done,    mIDone);
        check("d_done",    ifc.d_done,    mDDone);
        check("i_data",    ifc.i_data,    mIData);
        check("d_data",    ifc.d_data,    mDData);
        check("mem_rd",    ifc.mem_rd,    txValid && txAge == 0 && !txWr);
        check("mem_wr",    ifc.mem_wr,    txValid && txAge == 0 && txWr);
        check("mem_addr",  ifc.mem_addr,  mMemAddr);
        check("mem_wdata", ifc.mem_wdata, mMemWdata);
        check("err",       ifc.err,       mErr);
    endtask

    // Inputs are set by the caller after a falling edge; the model consumes
    // them at the rising edge and outputs are compared at the next falling edge.
    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        cyc++;
        compareAll();
    endtask

    task automatic setIdle();
        ifc.i_req = 0; ifc.i_addr = 0;
        ifc.d_req = 0; ifc.d_wr = 0; ifc.d_addr = 0; ifc.d_wdata = 0;
        ifc.mem_done = 0; ifc.mem_rdata = 0; ifc.mem_err = 0;
    endtask

    task automatic doReset();
        setIdle();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic randInputs(input bit errMode);
        ifc.i_req  = ((!mIPend) || (errMode && $urandom_range(0, 7) == 0)) && $urandom_range(0, 3) == 0;
        ifc.i_addr = 16'($urandom);
        ifc.d_req  = ((!mDPend) || (errMode && $urandom_range(0, 7) == 0)) && $urandom_range(0, 2) == 0;
        ifc.d_wr   = 1'($urandom);
        ifc.d_addr = 16'($urandom);
        ifc.d_wdata = 16'($urandom);
        ifc.mem_rdata = 16'($urandom);
        if (txValid && txAge == 0) begin
            if (errMode && $urandom_range(0, 4) == 0) doneAge = 100;
            else doneAge = $urandom_range(0, 6);
        end
        if (txValid) ifc.mem_done = (txAge == doneAge);
        else ifc.mem_done = errMode && $urandom_range(0, 31) == 0;
        ifc.mem_err = errMode && $urandom_range(0, 63) == 0;
    endtask

    initial begin
        doneAge = 0;
        setIdle();
        doReset();
        check("reset d_busy", ifc.d_busy, 1'b0);
        check("reset mem_rd", ifc.mem_rd, 1'b0);
        check("reset err",    ifc.err,    1'b0);

        // D read of 0x0040, Done at cycle 5 with 0xBEEF
        cyc = 0;
        ifc.d_req = 1; ifc.d_wr = 0; ifc.d_addr = 16'h0040;
        tick(); setIdle();
        check("rd busy c1", ifc.d_busy, 1'b1);
        tick();
        check("rd mem_rd c2", ifc.mem_rd, 1'b1);
        check("rd addr c2", ifc.mem_addr, 16'h0040);
        repeat (3) tick();
        ifc.mem_done = 1; ifc.mem_rdata = 16'hBEEF;
        tick(); setIdle();
        check("rd d_done c6", ifc.d_done, 1'b1);
        check("rd d_data c6", ifc.d_data, 16'hBEEF);
        check("rd busy c6", ifc.d_busy, 1'b0);

        // D write 0x1234 to 0x0100
        cyc = 0;
        ifc.d_req = 1; ifc.d_wr = 1; ifc.d_addr = 16'h0100; ifc.d_wdata = 16'h1234;
        tick(); setIdle();
        tick();
        check("wr mem_wr c2", ifc.mem_wr, 1'b1);
        check("wr mem_rd c2", ifc.mem_rd, 1'b0);
        check("wr wdata c2", ifc.mem_wdata, 16'h1234);
        tick();
        check("wr mem_wr c3", ifc.mem_wr, 1'b0);
        check("wr wdata c3", ifc.mem_wdata, 16'h1234);
        ifc.mem_done = 1; ifc.mem_rdata = 16'h5555;
        tick(); setIdle();
        check("wr d_done", ifc.d_done, 1'b1);
        check("wr d_data", ifc.d_data, 16'h0000);

        // Simultaneous I and D: D first, I after d_done
        cyc = 0;
        ifc.i_req = 1; ifc.i_addr = 16'h0A00;
        ifc.d_req = 1; ifc.d_wr = 0; ifc.d_addr = 16'h0D00;
        tick(); setIdle();
        tick();
        check("sim D addr", ifc.mem_addr, 16'h0D00);
        check("sim i_busy c2", ifc.i_busy, 1'b1);
        tick();
        ifc.mem_done = 1; ifc.mem_rdata = 16'h1111;
        tick(); setIdle();
        check("sim d_data", ifc.d_data, 16'h1111);
        check("sim i_busy c4", ifc.i_busy, 1'b1);
        tick();
        check("sim I rd", ifc.mem_rd, 1'b1);
        check("sim I addr", ifc.mem_addr, 16'h0A00);
        ifc.mem_done = 1; ifc.mem_rdata = 16'h2222;
        tick(); setIdle();
        check("sim i_done", ifc.i_done, 1'b1);
        check("sim i_data", ifc.i_data, 16'h2222);
        check("sim err clean", ifc.err, 1'b0);

        // Timeout: Done never arrives
        cyc = 0;
        ifc.d_req = 1; ifc.d_wr = 0; ifc.d_addr = 16'h0777;
        tick(); setIdle();
        repeat (9) tick();
        check("to err c10", ifc.err, 1'b0);
        tick();
        check("to err c11", ifc.err, 1'b1);
        check("to d_done", ifc.d_done, 1'b1);
        check("to d_data", ifc.d_data, 16'h0000);

        // Request while busy, then reset mid-WAIT
        doReset();
        cyc = 0;
        ifc.d_req = 1; ifc.d_wr = 0; ifc.d_addr = 16'h0300;
        tick();
        ifc.d_addr = 16'h2222;
        tick(); setIdle();
        check("busy err", ifc.err, 1'b1);
        check("busy addr kept", ifc.mem_addr, 16'h0300);
        tick();
        rst = 1;
        tick(); rst = 0;
        check("rst d_busy", ifc.d_busy, 1'b0);
        check("rst err", ifc.err, 1'b0);
        check("rst mem_addr", ifc.mem_addr, 16'h0000);
        repeat (10) tick();
        check("rst no done", ifc.d_done, 1'b0);

        // Randomized traffic
        for (int seg = 0; seg < 30; seg++) begin
            bit errMode;
            errMode = (seg % 3 == 2);
            doReset();
            for (int k = 0; k < 150; k++) begin
                randInputs(errMode);
                rst = ($urandom_range(0, 199) == 0);
                tick();
                rst = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
